// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - mm:ss:cc up/down stopwatch with debounced keys and a circular lap buffer
module stopwatch_lap #(
    parameter int TICK_DIV  = 500000,
    parameter int DEBOUNCE  = 1000000,
    parameter int LAP_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_start_pause,
    input  logic                               key_lap,
    input  logic                               key_clear,
    input  logic                               key_mode,
    input  logic [23:0]                        preset_bcd,
    output logic [23:0]                        disp_bcd,
    output logic [1:0]                         state,
    output logic                               down_mode,
    output logic                               alarm,
    output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count
);

    localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } st_t;

    // key order in all 4-bit key vectors: 0 start/pause, 1 lap, 2 clear, 3 mode
    logic [3:0]    raw, sync1, sync2, lvl, press;
    logic [DW-1:0] db_cnt [4];

    st_t           st, st_n;
    logic [23:0]   count, count_n, count_t;
    logic [23:0]   frozen, frozen_n, disp_n;
    logic          split, split_n, recall, recall_n, down_n, lap_we, tick;
    logic [PW-1:0] ridx, ridx_n, wr_ptr, wr_ptr_n, rd_addr;
    logic [CW-1:0] lap_count_n;
    logic [TW-1:0] psc, psc_n;
    logic [23:0]   lap_mem [LAP_DEPTH];
    logic          start_e, clear_e, lap_e, mode_e;

    assign raw   = {key_mode, key_clear, key_lap, key_start_pause};
    assign state = st;

    // Presses resolved by priority so only the strongest key of a cycle acts
    assign start_e = press[0];
    assign clear_e = press[2] & ~press[0];
    assign lap_e   = press[1] & ~press[0] & ~press[2];
    assign mode_e  = press[3] & ~(|press[2:0]);

    // One BCD step of the whole mm:ss:cc value; ss tens rolls at 5, every other digit at 9
    function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic down);
        logic [23:0] r;
        logic        c;
        logic [3:0]  d, lim;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = v[i*4 +: 4];
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (c) begin
                if (!down) begin
                    if (d >= lim) d = 4'd0;
                    else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = lim;
                    else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    // Synchronise each key, accept a new level after DEBOUNCE equal samples, pulse on accepted press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            lvl   <= '1;
            press <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    db_cnt[i] <= '0;
                    lvl[i]    <= sync2[i];
                    press[i]  <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Next-state decode: tick applied first, then the winning press for the current state
    always_comb begin
        tick        = (st == S_RUN) && (psc == TW'(TICK_DIV - 1));
        count_t     = tick ? bcd_step(count, down_mode) : count;
        st_n        = st;
        count_n     = count;
        frozen_n    = frozen;
        split_n     = split;
        recall_n    = recall;
        ridx_n      = ridx;
        down_n      = down_mode;
        lap_we      = 1'b0;
        wr_ptr_n    = wr_ptr;
        lap_count_n = lap_count;
        psc_n       = '0;
        case (st)
            S_IDLE: begin
                if (start_e) begin
                    if (!down_mode) begin
                        count_n = '0;
                        st_n    = S_RUN;
                    end else if (preset_bcd != '0) begin
                        count_n = preset_bcd;
                        st_n    = S_RUN;
                    end
                end else if (mode_e) begin
                    down_n = ~down_mode;
                end
            end
            S_RUN: begin
                count_n = count_t;
                psc_n   = tick ? '0 : psc + TW'(1);
                if (tick && down_mode && (count_t == '0)) begin
                    st_n    = S_DONE;
                    split_n = 1'b0;
                    psc_n   = '0;
                end else if (start_e) begin
                    st_n    = S_PAUSE;
                    split_n = 1'b0;
                    psc_n   = '0;
                end else if (lap_e) begin
                    // the stored and frozen value is the count before this cycle's tick
                    lap_we   = 1'b1;
                    wr_ptr_n = wr_ptr + PW'(1);
                    if (lap_count != CW'(LAP_DEPTH)) lap_count_n = lap_count + CW'(1);
                    split_n  = 1'b1;
                    frozen_n = count;
                end
            end
            S_PAUSE: begin
                if (start_e) begin
                    st_n     = S_RUN;
                    recall_n = 1'b0;
                end else if (clear_e) begin
                    st_n     = S_IDLE;
                    count_n  = '0;
                    recall_n = 1'b0;
                    split_n  = 1'b0;
                end else if (lap_e && (lap_count != '0)) begin
                    if (!recall) begin
                        recall_n = 1'b1;
                        ridx_n   = '0;
                    end else if (CW'(ridx) + CW'(1) == lap_count) begin
                        recall_n = 1'b0;
                    end else begin
                        ridx_n = ridx + PW'(1);
                    end
                end
            end
            S_DONE: begin
                if (clear_e) begin
                    st_n    = S_IDLE;
                    count_n = '0;
                end
            end
            default: st_n = S_IDLE;
        endcase
        // once the buffer has wrapped, the oldest entry sits at the write pointer
        rd_addr = ((lap_count == CW'(LAP_DEPTH)) ? wr_ptr : '0) + ridx_n;
        disp_n  = recall_n ? lap_mem[rd_addr] : (split_n ? frozen_n : count_n);
    end

    // State, count, display and lap buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            count     <= '0;
            frozen    <= '0;
            split     <= 1'b0;
            recall    <= 1'b0;
            ridx      <= '0;
            down_mode <= 1'b0;
            wr_ptr    <= '0;
            lap_count <= '0;
            psc       <= '0;
            disp_bcd  <= '0;
            alarm     <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else begin
            st        <= st_n;
            count     <= count_n;
            frozen    <= frozen_n;
            split     <= split_n;
            recall    <= recall_n;
            ridx      <= ridx_n;
            down_mode <= down_n;
            wr_ptr    <= wr_ptr_n;
            lap_count <= lap_count_n;
            psc       <= psc_n;
            disp_bcd  <= disp_n;
            alarm     <= (st_n == S_DONE);
            if (lap_we) lap_mem[wr_ptr] <= count;
        end
    end

endmodule
